if_fetch: RTL and testbench

Instruction-fetch engine between the PC register and the IF/ID pipeline register. Takes the current PC, reads the 32-bit instruction over the byte-wide shared memory port, returns PC+4 to the PC register and presents instruction+PC to decode. Drives a stall request to the pipeline controller while a fetch is outstanding and obeys the controller's 2-bit stall code and the branch flush.

---
 rtl/if_fetch_if.sv | 26 ++
 rtl/if_fetch.sv | 253 +++++++++++++++++++++++++
 tb/tb_if_fetch.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// Byte-wide shared memory port between the instruction-fetch engine and the
// memory arbiter. The fetch engine is the master: it drives the address and
// read strobe; the arbiter/memory side answers with a grant and, one cycle
// after a granted read, the read byte.
interface if_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              mem_grant;
    logic [7:0]        mem_din;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_rd;

    modport master (
        input  mem_grant,
        input  mem_din,
        output mem_a,
        output mem_rd
    );

    modport slave (
        output mem_grant,
        output mem_din,
        input  mem_a,
        input  mem_rd
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch engine between the PC register and the IF/ID register.
// Latches the PC, assembles a 32-bit little-endian instruction from four byte
// reads on the shared memory port, hands PC+4 back to the PC register and
// presents instruction+PC to decode. Requests an upstream stall while a fetch
// is outstanding and follows the pipeline controller's stall code and flush.
//
// Optional feature: define IF_ICACHE_EN to add a direct-mapped instruction
// cache of 2^CACHE_IDX_W words. Each entry carries a parity bit over data and
// tag; an entry whose parity no longer matches is treated as a miss.
module if_fetch #(
    parameter int ADDR_W      = 32,
    parameter int CACHE_IDX_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [1:0]        stall,
    input  logic              flush,
    if_fetch_if.master        mem,
    output logic              stallreq_o,
    output logic [ADDR_W-1:0] pc_next_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              inst_valid_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] STALL_PASS = 2'b00;
    localparam logic [1:0] STALL_HOLD = 2'b01;
    localparam logic [1:0] STALL_BUBB = 2'b10;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_r;
    logic [ADDR_W-1:0] pc_o_r;
    logic [2:0]        issue_cnt_r;
    logic [2:0]        recv_cnt_r;
    logic              pend_r;
    logic [23:0]       word_r;
    logic [31:0]       inst_r;
    logic              valid_r;
    logic              stallreq_r;

    logic              rd_s;
    logic              cap_s;
    logic              last_s;
    logic              hit_s;
    logic              load_hit_s;
    logic [31:0]       hit_word_s;
    logic [31:0]       fill_word_s;

    // Memory-side strobes: issue while granted and bytes remain, capture the
    // byte of last cycle's granted read; a flush suppresses both.
    always_comb begin
        rd_s   = 1'b0;
        cap_s  = 1'b0;
        last_s = 1'b0;
        if ((state_r == S_FETCH) && !flush) begin
            rd_s   = mem.mem_grant && (issue_cnt_r < 3'd4);
            cap_s  = pend_r;
            last_s = pend_r && (recv_cnt_r == 3'd3);
        end else begin
            rd_s   = 1'b0;
            cap_s  = 1'b0;
            last_s = 1'b0;
        end
    end

    // The top byte arrives on the bus in the cycle the word completes.
    assign fill_word_s = {mem.mem_din, word_r};
    assign load_hit_s  = (state_r == S_IDLE) && !flush && hit_s;

    // Next-state decode; flush overrides everything, including the stall code.
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (hit_s) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (last_s) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_FETCH;
                    end
                end
                S_DONE: begin
                    case (stall)
                        STALL_PASS: state_s = S_IDLE;
                        STALL_BUBB: state_s = S_IDLE;
                        STALL_HOLD: state_s = S_DONE;
                        // Undefined code: keep the instruction rather than lose it.
                        default:    state_s = S_DONE;
                    endcase
                end
                default: state_s = S_IDLE;
            endcase
        end
    end

    // State register plus the state-decoded handshake flags, registered so
    // they only ever change on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            valid_r    <= 1'b0;
            stallreq_r <= 1'b1;
        end else begin
            state_r    <= state_s;
            valid_r    <= (state_s == S_DONE);
            stallreq_r <= (state_s != S_DONE);
        end
    end

    // PC latch in IDLE, together with its precomputed successor (wraps at 2^ADDR_W).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r      <= {ADDR_W{1'b0}};
            pc_next_r <= ADDR_W'(3'd4);
        end else if ((state_r == S_IDLE) && !flush) begin
            pc_r      <= pc_i;
            pc_next_r <= pc_i + ADDR_W'(3'd4);
        end
    end

    // Issue/receive byte counters and the one-cycle read-pending flag; both
    // counters restart whenever the engine is not actively fetching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_r <= 3'd0;
            recv_cnt_r  <= 3'd0;
            pend_r      <= 1'b0;
        end else begin
            pend_r <= rd_s;
            if ((state_r != S_FETCH) || flush) begin
                issue_cnt_r <= 3'd0;
                recv_cnt_r  <= 3'd0;
            end else begin
                if (rd_s) begin
                    issue_cnt_r <= issue_cnt_r + 3'd1;
                end
                if (cap_s) begin
                    recv_cnt_r <= recv_cnt_r + 3'd1;
                end
            end
        end
    end

    // Byte assembly (little-endian) and loading of the presented instruction,
    // either from the completed fetch or from a cache hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r <= 24'h000000;
            inst_r <= 32'h00000000;
            pc_o_r <= {ADDR_W{1'b0}};
        end else begin
            if (cap_s) begin
                case (recv_cnt_r)
                    3'd0:    word_r[7:0]   <= mem.mem_din;
                    3'd1:    word_r[15:8]  <= mem.mem_din;
                    3'd2:    word_r[23:16] <= mem.mem_din;
                    default: word_r        <= word_r;
                endcase
            end
            if (last_s) begin
                inst_r <= fill_word_s;
                pc_o_r <= pc_r;
            end else if (load_hit_s) begin
                inst_r <= hit_word_s;
                pc_o_r <= pc_i;
            end
        end
    end

`ifdef IF_ICACHE_EN
    localparam int TAG_W = ADDR_W - CACHE_IDX_W - 2;
    localparam int DEPTH = 1 << CACHE_IDX_W;

    function automatic logic entry_parity(input logic [31:0] data, input logic [TAG_W-1:0] tag);
        return ^{data, tag};
    endfunction

    logic [31:0]            cdata_r [DEPTH];
    logic [TAG_W-1:0]       ctag_r  [DEPTH];
    logic [DEPTH-1:0]       cpar_r;
    logic [DEPTH-1:0]       cvalid_r;
    logic [CACHE_IDX_W-1:0] ridx_s;
    logic [CACHE_IDX_W-1:0] widx_s;
    logic [TAG_W-1:0]       rtag_s;
    logic [TAG_W-1:0]       wtag_s;

    assign ridx_s = pc_i[CACHE_IDX_W+1:2];
    assign rtag_s = pc_i[ADDR_W-1:CACHE_IDX_W+2];
    assign widx_s = pc_r[CACHE_IDX_W+1:2];
    assign wtag_s = pc_r[ADDR_W-1:CACHE_IDX_W+2];

    // Lookup of pc_i: hit needs a valid entry, matching tag and intact parity.
    always_comb begin
        hit_s      = 1'b0;
        hit_word_s = cdata_r[ridx_s];
        if (cvalid_r[ridx_s] && (ctag_r[ridx_s] == rtag_s) &&
            (entry_parity(cdata_r[ridx_s], ctag_r[ridx_s]) == cpar_r[ridx_s])) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Data/tag storage, filled only on a completed (never an aborted) fetch.
    always_ff @(posedge clk) begin
        if (last_s) begin
            cdata_r[widx_s] <= fill_word_s;
            ctag_r[widx_s]  <= wtag_s;
        end
    end

    // Valid and parity bits; reset clears every valid bit, flush leaves them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cvalid_r <= {DEPTH{1'b0}};
            cpar_r   <= {DEPTH{1'b0}};
        end else if (last_s) begin
            cvalid_r[widx_s] <= 1'b1;
            cpar_r[widx_s]   <= entry_parity(fill_word_s, wtag_s);
        end
    end
`else
    assign hit_s      = 1'b0;
    assign hit_word_s = 32'h00000000;
`endif

    assign mem.mem_rd   = rd_s;
    assign mem.mem_a    = pc_r + ADDR_W'(issue_cnt_r);
    assign stallreq_o   = stallreq_r;
    assign pc_next_o    = pc_next_r;
    assign inst_o       = inst_r;
    assign pc_o         = pc_o_r;
    assign inst_valid_o = valid_r;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a byte-addressed memory model answers the
// shared port, expected fetch results are queued when a fetch is started and
// compared when the DUT presents a valid instruction.
module tb_if_fetch;

    localparam logic [1:0] PASS = 2'b00;
    localparam logic [1:0] HOLD = 2'b01;
    localparam logic [1:0] BUBB = 2'b10;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
        logic [31:0] pc_next;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] cyc;
    } rd_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_i  = 32'h0;
    logic [1:0]  stall = PASS;
    logic        flush = 1'b0;
    logic        stallreq_o;
    logic [31:0] pc_next_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_valid_o;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] cyc          = 32'd0;
    exp_t        sb[$];
    rd_t         rd_log[$];

    if_fetch_if #(.ADDR_W(32)) bus ();

    if_fetch #(.ADDR_W(32), .CACHE_IDX_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_i         (pc_i),
        .stall        (stall),
        .flush        (flush),
        .mem          (bus),
        .stallreq_o   (stallreq_o),
        .pc_next_o    (pc_next_o),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .inst_valid_o (inst_valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] b;
        if (a == 32'h0) b = 8'h13;
        else if (a < 32'h4) b = 8'h00;
        else b = (a[7:0] * 8'd37) + (a[15:8] * 8'd11) + a[31:24] + 8'h3C;
        return b;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
    endfunction

    // Memory model: a granted read returns its byte on the next cycle; reads are logged.
    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.mem_din <= mem_byte(bus.mem_a);
            rd_log.push_back({bus.mem_a, cyc});
        end else begin
            bus.mem_din <= 8'hEE;
        end
        cyc <= cyc + 32'd1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in an IDLE cycle; returns at the first DONE cycle (or on timeout).
    // Grant is low in fetch cycles gs .. gs+gl-1.
    task automatic run_fetch(input logic [31:0] pc, input int gs, input int gl,
                             input bit hit, input string tag);
        exp_t        e;
        exp_t        q;
        int          ek[4];
        int          n;
        int          kk;
        int          lat;
        int          k;
        logic [31:0] c0;
        bit          busy_ok;
        e.pc      = pc;
        e.word    = exp_word(pc);
        e.pc_next = pc + 32'd4;
        sb.push_back(e);
        n  = 0;
        kk = 1;
        while (n < 4) begin
            if (!(kk >= gs && kk < gs + gl)) begin
                ek[n] = kk;
                n++;
            end
            kk++;
        end
        lat = hit ? 1 : ek[3] + 2;
        rd_log.delete();
        c0            = cyc;
        pc_i          = pc;
        bus.mem_grant = 1'b1;
        k             = 0;
        busy_ok       = 1'b1;
        while (k < 60 && !inst_valid_o) begin
            if (!stallreq_o) busy_ok = 1'b0;
            step();
            k++;
            bus.mem_grant = !(k >= gs && k < gs + gl);
        end
        check({tag, "_latency"}, 64'(k), 64'(lat));
        check({tag, "_stallreq_busy"}, 64'(busy_ok), 64'd1);
        if (inst_valid_o) begin
            q = sb.pop_front();
            check({tag, "_inst"}, 64'(inst_o), 64'(q.word));
            check({tag, "_pc_o"}, 64'(pc_o), 64'(q.pc));
            check({tag, "_pc_next"}, 64'(pc_next_o), 64'(q.pc_next));
            check({tag, "_stallreq_done"}, 64'(stallreq_o), 64'd0);
        end else begin
            check({tag, "_valid_timeout"}, 64'd0, 64'd1);
            sb.delete();
        end
        if (hit) begin
            check({tag, "_nreads"}, 64'(rd_log.size()), 64'd0);
        end else begin
            check({tag, "_nreads"}, 64'(rd_log.size()), 64'd4);
            for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
                check({tag, "_rd_addr"}, 64'(rd_log[i].addr), 64'(pc + 32'(i)));
                check({tag, "_rd_cycle"}, 64'(rd_log[i].cyc - c0), 64'(ek[i]));
            end
        end
        bus.mem_grant = 1'b1;
    endtask

    // Leave DONE with Pass; the next cycle must be IDLE.
    task automatic release_pass(input string tag);
        stall = PASS;
        step();
        check({tag, "_pass_valid"}, 64'(inst_valid_o), 64'd0);
        check({tag, "_pass_stallreq"}, 64'(stallreq_o), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_grant = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stallreq", 64'(stallreq_o), 64'd1);
        check("rst_valid", 64'(inst_valid_o), 64'd0);
        check("rst_inst", 64'(inst_o), 64'd0);
        check("rst_pc_o", 64'(pc_o), 64'd0);
        check("rst_mem_rd", 64'(bus.mem_rd), 64'd0);
        check("rst_pc_next", 64'(pc_next_o), 64'd4);
        rst_n = 1'b1;

        // First fetch after reset at PC 0.
        run_fetch(32'h0, 0, 0, 1'b0, "f0");
        check("f0_word_const", 64'(inst_o), 64'h13);
        release_pass("f0");

        // Grant withheld in fetch cycles 2-3, then hold for three cycles.
        run_fetch(32'h100, 2, 2, 1'b0, "f_gap");
        stall = HOLD;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_valid", 64'(inst_valid_o), 64'd1);
            check("hold_inst", 64'(inst_o), 64'(exp_word(32'h100)));
            check("hold_pc_o", 64'(pc_o), 64'h100);
            check("hold_stallreq", 64'(stallreq_o), 64'd0);
        end
        release_pass("hold");

        // Flush in the cycle after the second byte issue.
        pc_i = 32'h300;
        bus.mem_grant = 1'b1;
        step();
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", 64'(inst_valid_o), 64'd0);
        check("flush_stallreq", 64'(stallreq_o), 64'd1);
        run_fetch(32'h200, 0, 0, 1'b0, "f_after_flush");
        release_pass("f200");

        // PC wrap and bubble.
        run_fetch(32'hFFFF_FFFC, 1, 1, 1'b0, "f_wrap");
        check("wrap_pc_next", 64'(pc_next_o), 64'd0);
        stall = BUBB;
        step();
        check("bubb_valid", 64'(inst_valid_o), 64'd0);
        check("bubb_stallreq", 64'(stallreq_o), 64'd1);
        stall = PASS;

        // Flush wins over Hold in DONE.
        run_fetch(32'h500, 0, 0, 1'b0, "f500");
        stall = HOLD;
        flush = 1'b1;
        step();
        flush = 1'b0;
        stall = PASS;
        check("flush_hold_valid", 64'(inst_valid_o), 64'd0);

        // Reset in the middle of a fetch.
        pc_i = 32'h400;
        bus.mem_grant = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_rd", 64'(bus.mem_rd), 64'd0);
        check("midrst_valid", 64'(inst_valid_o), 64'd0);
        check("midrst_stallreq", 64'(stallreq_o), 64'd1);
        check("midrst_inst", 64'(inst_o), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_fetch(32'h0, 0, 0, 1'b0, "f0_again");
        release_pass("f0_again");

        // Distinct PCs with random grant gaps.
        for (int i = 0; i < 4; i++) begin
            run_fetch(32'h1000 + 32'(i) * 32'h44, int'($urandom_range(1, 5)),
                      int'($urandom_range(0, 3)), 1'b0, "f_rand");
            release_pass("f_rand");
        end

`ifdef IF_ICACHE_EN
        run_fetch(32'h40, 0, 0, 1'b0, "c_miss");
        release_pass("c_miss");
        run_fetch(32'h40, 0, 0, 1'b1, "c_hit");
        release_pass("c_hit");
        run_fetch(32'h140, 0, 0, 1'b0, "c_conflict");
        release_pass("c_conflict");
`endif

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
